inst_mem_ctrl: RTL

Parametrised instruction memory with a handshaked loader port and a registered fetch port for the core front end. An external loader streams byte-addressed instruction words into block RAM, and the fetch stage then reads word-aligned instructions with one-cycle latency. Misaligned and out-of-range fetches are flagged, not silently aliased. A three-state controller sequences reset, load and run.

---
 rtl/inst_mem_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/inst_mem_ctrl.sv
// -----------------------------------------------------------------------------
// inst_mem_ctrl
//
// Instruction memory for the core front end. An external loader streams
// byte-addressed instruction words into a block RAM. The fetch stage then reads
// word-aligned instructions with one cycle of latency. A three-state controller
// (IDLE -> LOAD -> RUN, with reload from RUN) sequences the two phases.
// Misaligned and out-of-range fetches return NOP with fetch_fault set instead
// of aliasing onto another word.
//
// Optional feature:
//   IMEM_WRAP_EN  - when defined, fetches use fetch_pc[H+1:2] as the index and
//                   wrap modulo 2**H words. fetch_fault then flags misalignment
//                   only. Loader range checking is unchanged.
//
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   load_start    - pulse, enters LOAD from IDLE or RUN
//   load_valid    - loader word valid (handshake with load_ready)
//   load_addr     - byte address of loader word
//   load_data     - instruction word to store
//   load_last     - marks final loader word, completes the load
//   load_ready    - high only while in LOAD
//   load_count    - words accepted this load, saturating at 2**H
//   load_err      - sticky: a loader word was dropped (misaligned/out of range)
//   fetch_req     - fetch request, honoured in RUN when load_start is low
//   fetch_pc      - byte address to fetch
//   fetch_valid   - one-cycle pulse, fetch_inst/fetch_fault are fresh
//   fetch_inst    - fetched instruction (NOP on fault)
//   fetch_fault   - misaligned or out-of-range fetch
//   busy          - high in IDLE and LOAD
// -----------------------------------------------------------------------------
module inst_mem_ctrl #(
    parameter int unsigned  W   = 32,
    parameter int unsigned  H   = 8,
    parameter logic [W-1:0] NOP = 32'h00000013
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_start,
    input  logic         load_valid,
    input  logic [W-1:0] load_addr,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    output logic         load_ready,
    output logic [H:0]   load_count,
    output logic         load_err,
    input  logic         fetch_req,
    input  logic [W-1:0] fetch_pc,
    output logic         fetch_valid,
    output logic [W-1:0] fetch_inst,
    output logic         fetch_fault,
    output logic         busy
);

    localparam int unsigned DEPTH     = 2 ** H;
    localparam logic [H:0]  COUNT_ONE = {{H{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t       state_q, state_d;
    logic [H:0]   load_count_q, load_count_d;
    logic         load_err_q, load_err_d;
    logic         fetch_valid_q, fetch_valid_d;
    logic         fetch_fault_q, fetch_fault_d;
    logic [W-1:0] rd_word_q;

    logic [W-1:0] mem [DEPTH];

    logic         load_hs;
    logic         load_ok;
    logic         mem_we;
    logic         fetch_acc;
    logic         fetch_bad;
    logic [H-1:0] load_idx;
    logic [H-1:0] fetch_idx;

    // Handshake and address decode for both ports.
    assign load_hs   = load_valid && (state_q == S_LOAD);
    assign load_idx  = load_addr[H+1:2];
    assign load_ok   = (load_addr[1:0] == 2'b00) && (load_addr[W-1:H+2] == '0);
    // rst wins over a same-edge handshake so nothing is written while resetting.
    assign mem_we    = load_hs && load_ok && !rst;

    // load_start wins a same-cycle collision; the fetch is dropped.
    assign fetch_acc = fetch_req && (state_q == S_RUN) && !load_start;
    assign fetch_idx = fetch_pc[H+1:2];

`ifdef IMEM_WRAP_EN
    assign fetch_bad = (fetch_pc[1:0] != 2'b00);
`else
    assign fetch_bad = (fetch_pc[1:0] != 2'b00) || (fetch_pc[W-1:H+2] != '0);
`endif

    // Next-state and register-input logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        load_count_d  = load_count_q;
        load_err_d    = load_err_q;
        fetch_valid_d = fetch_acc;
        fetch_fault_d = fetch_fault_q;

        unique case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d      = S_LOAD;
                    load_count_d = '0;
                    load_err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (load_hs) begin
                    if (load_ok) begin
                        // Top bit set means the count has reached 2**H.
                        if (!load_count_q[H]) begin
                            load_count_d = load_count_q + COUNT_ONE;
                        end
                    end else begin
                        load_err_d = 1'b1;
                    end
                    // A dropped last word still completes the load.
                    if (load_last) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (load_start) begin
                    state_d      = S_LOAD;
                    load_count_d = '0;
                    load_err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fetch_acc) begin
            fetch_fault_d = fetch_bad;
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q       <= S_IDLE;
            load_count_q  <= '0;
            load_err_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_count_q  <= load_count_d;
            load_err_q    <= load_err_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    // Block RAM write port.
    // NOTE: the array itself is deliberately never reset; a reset would stop
    // it mapping to block RAM and would also erase a program that is meant to
    // survive rst and reload.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_idx] <= load_data;
        end
    end

    // Block RAM synchronous read port. Its output register only updates on an
    // accepted fetch, so the last result is held between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_word_q <= '0;
        end else if (fetch_acc) begin
            rd_word_q <= mem[fetch_idx];
        end
    end

    assign load_ready  = (state_q == S_LOAD);
    assign busy        = (state_q != S_RUN);
    assign load_count  = load_count_q;
    assign load_err    = load_err_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign fetch_inst  = fetch_fault_q ? NOP : rd_word_q;

endmodule
